// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit controller: FSM states, bus mode and word sizes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // Mode 0 matches the AES core receiver: sample on SCLK rise, drive on SCLK fall.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  localparam int DATA_W_128 = 128;
  localparam int DATA_W_192 = 192;
  localparam int DATA_W_256 = 256;

  function automatic bit legal_data_w(input int w);
    return (w == DATA_W_128) || (w == DATA_W_192) || (w == DATA_W_256);
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Host-side handshake between the control logic and the SPI transmit controller.
interface spi_master_tx_if #(
  parameter int DATA_W = 128
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (output start, output tx_data, input busy, input done, input rx_data);
  modport slave  (input start, input tx_data, output busy, output done, output rx_data);
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + DIV_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == TERM);
endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts one DATA_W word out on MOSI (MSB first) and captures MISO.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_tx_if.slave host,
  output logic          sclk,
  output logic          cs_n,
  output logic          mosi,
  input  logic          miso
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  spi_state_t        state, state_nxt;
  logic              accept, rise, fall, fin;
  logic              tick;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sclk_q, done_q;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One extra low half-period after the last fall keeps the SCLK duty at 50%
  // before HOLD; that tick ends XFER instead of producing another rise.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          rise      = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sclk_q)                    fall      = 1'b1;
          else if (bit_cnt == LAST_BIT)  state_nxt = HOLD;
          else                           rise      = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MISO is captured on the edge that raises SCLK, i.e. the value the slave
  // set up during the preceding low half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
      sclk_q  <= CPOL;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (accept) begin
        tx_sr   <= host.tx_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end
      if (rise) begin
        sclk_q <= 1'b1;
        rx_sr  <= {rx_sr[DATA_W-2:0], miso};
      end
      if (fall) begin
        sclk_q  <= 1'b0;
        tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (fin) rx_q <= rx_sr;
    end
  end

  // Shifted-out register is all zeros after the last fall, so MOSI idles at 0.
  assign sclk         = sclk_q;
  assign cs_n         = (state == IDLE);
  assign mosi         = tx_sr[DATA_W-1];
  assign host.busy    = (state != IDLE);
  assign host.done    = done_q;
  assign host.rx_data = rx_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: 128-bit/CLK_DIV=2 instance and 256-bit/CLK_DIV=1 instance.
module tb_spi_master_tx;
  localparam logic [127:0] SLV_RESP = 128'hFFEEDDCCBBAA99887766554433221100;

  typedef struct {
    logic [255:0] rx;
    logic [255:0] tx;
    bit           chkcap;
    int           t0;
  } exp_t;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic sclk_a, cs_n_a, mosi_a, miso_a;
  logic sclk_b, cs_n_b, mosi_b, miso_b;
  bit   loop_a = 1'b1;
  logic [127:0] s_resp = '0;
  logic [127:0] cap_a = '0;
  int   rises_a = 0;
  int   rises_b = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  spi_master_tx_if #(.DATA_W(128)) ifa ();
  spi_master_tx_if #(.DATA_W(256)) ifb ();

  spi_master_tx #(.DATA_W(128), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .host(ifa),
    .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master_tx #(.DATA_W(256), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .host(ifb),
    .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
  );

  assign miso_a = loop_a ? mosi_a : s_resp[127];
  assign miso_b = mosi_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Mode-0 slave: MSB out at CS fall, sample MOSI on rise, next bit on fall.
  initial begin
    logic cp, sp;
    cp = 1'b1;
    sp = 1'b0;
    forever begin
      @(cs_n_a or sclk_a);
      if (!cs_n_a && cp)  begin s_resp = SLV_RESP; cap_a = '0; end
      if (sclk_a && !sp)  cap_a = {cap_a[126:0], mosi_a};
      if (!sclk_a && sp)  s_resp = s_resp << 1;
      cp = cs_n_a;
      sp = sclk_a;
    end
  end

  // Monitor A: pops one expectation per done pulse.
  initial begin
    exp_t e;
    logic sq, cq;
    sq = 1'b0;
    cq = 1'b1;
    forever begin
      @(negedge clk);
      if (!cs_n_a && cq) rises_a = 0;
      if (sclk_a && !sq) rises_a++;
      if (ifa.done) begin
        if (sb_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_done actual=done required=none");
        end else begin
          e = sb_a.pop_front();
          chk("a_rx_data", 256'(ifa.rx_data), e.rx);
          chk("a_latency", 256'(cyc - e.t0), 256'(517));
          chk("a_sclk_rises", 256'(rises_a), 256'(128));
          if (e.chkcap) chk("a_slave_capture", 256'(cap_a), e.tx);
        end
      end
      sq = sclk_a;
      cq = cs_n_a;
    end
  end

  // Monitor B: also checks the SCLK period at every rise after the first.
  initial begin
    exp_t e;
    logic sq, cq;
    int   last;
    sq = 1'b0;
    cq = 1'b1;
    last = 0;
    forever begin
      @(negedge clk);
      if (!cs_n_b && cq) rises_b = 0;
      if (sclk_b && !sq) begin
        if (rises_b > 0) chk("b_sclk_period", 256'(cyc - last), 256'(2));
        last = cyc;
        rises_b++;
      end
      if (ifb.done) begin
        if (sb_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_done actual=done required=none");
        end else begin
          e = sb_b.pop_front();
          chk("b_rx_data", 256'(ifb.rx_data), e.rx);
          chk("b_latency", 256'(cyc - e.t0), 256'(515));
          chk("b_sclk_rises", 256'(rises_b), 256'(256));
        end
      end
      sq = sclk_b;
      cq = cs_n_b;
    end
  end

  // Called at a falling clock edge; start is sampled at the next rising edge.
  task automatic go_a(input logic [127:0] d, input logic [127:0] exp_rx, input bit capchk);
    exp_t e;
    e.rx = 256'(exp_rx);
    e.tx = 256'(d);
    e.chkcap = capchk;
    e.t0 = cyc;
    sb_a.push_back(e);
    ifa.tx_data = d;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifa.tx_data = ~d;
  endtask

  task automatic wait_done_a();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = ifa.done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL a_done_timeout actual=none required=done");
    end
  endtask

  task automatic wait_done_b();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = ifb.done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL b_done_timeout actual=none required=done");
    end
  endtask

  initial begin
    exp_t eb;
    rst = 1'b1;
    ifa.start = 1'b0;
    ifa.tx_data = '0;
    ifb.start = 1'b0;
    ifb.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 256'(cs_n_a), 256'(1));
    chk("rst_sclk", 256'(sclk_a), 256'(0));
    chk("rst_mosi", 256'(mosi_a), 256'(0));
    chk("rst_busy", 256'(ifa.busy), 256'(0));
    chk("rst_done", 256'(ifa.done), 256'(0));
    chk("rst_rx_data", 256'(ifa.rx_data), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Loopback of the byte-index pattern.
    loop_a = 1'b1;
    go_a(128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    chk("a_cs_n_low_t1", 256'(cs_n_a), 256'(0));
    chk("a_busy_t1", 256'(ifa.busy), 256'(1));
    wait_done_a();
    @(negedge clk);

    // Behavioural slave returns a fixed word and captures the key block.
    loop_a = 1'b0;
    go_a(128'h2B7E151628AED2A6ABF7158809CF4F3C, SLV_RESP, 1'b1);
    wait_done_a();
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle.
    loop_a = 1'b1;
    go_a({16{8'h5A}}, {16{8'h5A}}, 1'b0);
    wait_done_a();
    chk("b2b_cs_n_high_done", 256'(cs_n_a), 256'(1));
    go_a({16{8'hA5}}, {16{8'hA5}}, 1'b0);
    chk("b2b_cs_n_low_next", 256'(cs_n_a), 256'(0));
    wait_done_a();
    @(negedge clk);

    // Start pulse with a different word in the middle of XFER is ignored.
    go_a(128'h112233445566778899AABBCCDDEEFF00, 128'h112233445566778899AABBCCDDEEFF00, 1'b0);
    repeat (100) @(negedge clk);
    ifa.tx_data = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done_a();
    repeat (30) @(negedge clk);
    chk("ign_busy_after", 256'(ifa.busy), 256'(0));
    chk("ign_cs_n_after", 256'(cs_n_a), 256'(1));

    // Asynchronous reset after the 60th SCLK rise aborts the transfer.
    go_a(128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D, 128'h0, 1'b0);
    for (int i = 0; i < 2000 && rises_a < 60; i++) @(negedge clk);
    chk("rst_mid_reached_bit60", 256'(rises_a), 256'(60));
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", 256'(cs_n_a), 256'(1));
    chk("rst_mid_sclk", 256'(sclk_a), 256'(0));
    chk("rst_mid_mosi", 256'(mosi_a), 256'(0));
    chk("rst_mid_busy", 256'(ifa.busy), 256'(0));
    chk("rst_mid_done", 256'(ifa.done), 256'(0));
    chk("rst_mid_rx_data", 256'(ifa.rx_data), 256'(0));
    sb_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go_a(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b0);
    wait_done_a();
    @(negedge clk);

    // 256-bit word at the fastest divider, incrementing-byte loopback.
    eb.rx = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    eb.tx = eb.rx;
    eb.chkcap = 1'b0;
    eb.t0 = cyc;
    sb_b.push_back(eb);
    ifb.tx_data = eb.rx;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    ifb.tx_data = '0;
    wait_done_b();
    repeat (5) @(negedge clk);

    chk("a_scoreboard_drained", 256'(sb_a.size()), 256'(0));
    chk("b_scoreboard_drained", 256'(sb_b.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
